pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
- Program-counter stage that owns the PC register and selects the next PC.
- Consumes the word-aligned branch offset produced by the shift-left-by-2 stage, plus jump and jump-register controls from decode.
- Presents the current PC to instruction fetch over a valid/ready handshake.
- Buffers one pending redirect when fetch back-pressures, so no taken branch or jump is lost.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- PC_STEP, 4, byte increment for sequential fetch.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- PCOut  output  32  PC presented to fetch
- PCPlus4  output  32  PCOut + PC_STEP, combinational, for the link register and the branch adder
- PCValid  output  1  PCOut is valid for fetch
- PCReady  input  1  fetch accepts PCOut this cycle
- Stall  input  1  pipeline hazard; freezes the PC even if PCReady=1
- BranchTaken  input  1  branch redirect request
- BranchOffset  input  32  sign-extended offset, already shifted left by 2
- Jump  input  1  j/jal redirect request
- JumpIndex  input  26  instr[25:0]
- JumpReg  input  1  jr/jalr redirect request
- RegTarget  input  32  rs value for jr
- Misalign  output  1  sticky flag: a jr target had nonzero bits [1:0]

Behaviour:
- Reset (rst=1 at a clk edge):
  - PCOut=RESET_PC, PCValid=0, pending register cleared (PendValid=0, PendTarget=0), Misalign=0.
  - Reset overrides every other input, including in the middle of a pending redirect.
- States:
  - BOOT: one cycle after reset release, PCValid=0. Transition to RUN unconditionally.
  - RUN: PCValid=1 continuously, never deasserted except by reset.
- Accept: Accept = PCValid & PCReady & ~Stall. The PC changes only on Accept.
- Redirect request and target (combinational, relative to the current PCOut; priority JumpReg > Jump > BranchTaken):
  - JumpReg: {RegTarget[31:2],2'b00}.
  - Jump: {PCPlus4[31:28], JumpIndex, 2'b00}.
  - BranchTaken: PCPlus4 + BranchOffset, modulo 2^32.
- Next PC on Accept, in priority order:
  - Same-cycle redirect target.
  - Else PendTarget if PendValid.
  - Else PCPlus4.
  - Accept clears PendValid.
- Redirect without Accept (in RUN): latch the target into PendTarget and set PendValid=1. A later redirect before Accept overwrites PendTarget (newest wins).
- Redirect inputs in BOOT are ignored.
- Latency: PC updates on the edge that completes Accept; the new PCOut is visible the following cycle. Throughput is one PC per cycle with PCReady=1 and Stall=0.
- Arithmetic: all 32-bit unsigned, wrap-around. 0xFFFFFFFC + 4 = 0x00000000. No overflow flag.
- Misalign: set on any cycle in RUN where JumpReg=1 and RegTarget[1:0]!=0. Cleared only by rst.
- Stall=1 with PCReady=1: no Accept; PCOut holds; any redirect goes to the pending register.

Test Plan:
- Reset then PCReady=1 held: PCValid=0 for one cycle, then PCOut sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Branch: at PCOut=0x10, BranchTaken=1, BranchOffset=0x00000020 -> next PCOut=0x34. At PCOut=0x20, BranchOffset=0xFFFFFFF0 -> next PCOut=0x14.
- Jump: at PCOut=0x10, Jump=1, JumpIndex=0x0000100 -> next PCOut=0x00000400. Jump, JumpReg (RegTarget=0x2000) and BranchTaken asserted together -> 0x2000.
- Back-pressure: at PCOut=0x10, BranchTaken=1, offset=0x8, PCReady=0 for 3 cycles -> PCOut holds 0x10. First Accept then gives 0x1C. A second redirect during the wait (Jump, JumpIndex=0x40) -> 0x100 instead.
- Misaligned jr: JumpReg=1, RegTarget=0x00001002 -> next PCOut=0x00001000, Misalign=1 and stays 1 until rst.
- Wrap and reset mid-operation: force PC to 0xFFFFFFFC via jr -> next PCOut=0x0. Assert rst while PendValid=1 -> PCOut=RESET_PC, PendValid=0, PCValid=0.

Source files
------------

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - program counter register with next-PC selection, fetch handshake and one-deep redirect buffer
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PCOut,
    output logic [31:0] PCPlus4,
    output logic        PCValid,
    input  logic        PCReady,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchOffset,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
    output logic        Misalign
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        pc_valid_q;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        misalign_q;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        accept;
    logic        jr_misaligned;
    logic [31:0] next_pc;

    assign PCOut    = pc_q;
    assign PCPlus4  = pc_q + PC_STEP;
    assign PCValid  = pc_valid_q;
    assign Misalign = misalign_q;

    // Fetch takes the PC only when valid, ready and not frozen by a hazard
    assign accept = pc_valid_q & PCReady & ~Stall;

    // Redirects are only meaningful once the PC is live; BOOT ignores them
    assign redirect = (state == RUN) & (JumpReg | Jump | BranchTaken);

    assign jr_misaligned = (state == RUN) & JumpReg & (RegTarget[1:0] != 2'b00);

    // Redirect target, jr beats j beats branch when several are raised together
    always_comb begin
        redirect_target = PCPlus4 + BranchOffset;
        if (JumpReg) begin
            redirect_target = {RegTarget[31:2], 2'b00};
        end else if (Jump) begin
            redirect_target = {PCPlus4[31:28], JumpIndex, 2'b00};
        end
    end

    // PC taken on accept: a live redirect wins, then a buffered one, then sequential
    always_comb begin
        next_pc = PCPlus4;
        if (redirect) begin
            next_pc = redirect_target;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end
    end

    // State machine owning the PC, the pending redirect and the sticky misalign flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc_q        <= RESET_PC;
            pc_valid_q  <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= 32'h00000000;
            misalign_q  <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_valid_q <= 1'b1;
                end
                RUN: begin
                    pc_valid_q <= 1'b1;
                    if (jr_misaligned) begin
                        misalign_q <= 1'b1;
                    end
                    if (accept) begin
                        pc_q       <= next_pc;
                        pend_valid <= 1'b0;
                    end else if (redirect) begin
                        pend_target <= redirect_target;
                        pend_valid  <= 1'b1;
                    end
                end
                default: begin
                    state      <= BOOT;
                    pc_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
